// File: rtl/fwd_pkg.sv
// +----------------------------------------------------------------------------+
// | fwd_pkg: shared types for the forwarding / load-use hazard unit            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fwd_pkg;

  // Slot field widths; the top-level XLEN/REG_AW parameters must match these.
  localparam int unsigned FWD_XLEN   = 32;
  localparam int unsigned FWD_REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  we;
    logic                  is_load;
    logic [FWD_XLEN-1:0]   data;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  function automatic logic slot_writes(input slot_t s, input logic [FWD_REG_AW-1:0] r);
    return s.valid && s.we && (s.rd == r) && (r != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_operand_sel.sv
// +----------------------------------------------------------------------------+
// | fwd_operand_sel: compare-and-mux for one EX source operand                 |
// | Build option: FWD_LOAD_BYPASS_EN enables the MEM load-data select (11).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = FWD_XLEN,
  parameter int unsigned REG_AW = FWD_REG_AW
) (
  input  slot_t             mem_slot_i,
  input  slot_t             wb_slot_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   rdata_i,
  input  logic [XLEN-1:0]   load_data_i,
  output logic [XLEN-1:0]   op_o,
  output logic [1:0]        sel_o
);

`ifdef FWD_LOAD_BYPASS_EN
  localparam logic LD_BYPASS = 1'b1;
`else
  localparam logic LD_BYPASS = 1'b0;
`endif

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = slot_writes(mem_slot_i, rs_i);
  assign wb_hit  = slot_writes(wb_slot_i, rs_i);

  // Youngest writer wins; a MEM load only forwards when memory is single-cycle.
  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit && !mem_slot_i.is_load) begin
      sel_o = FWD_MEM;
    end else if (LD_BYPASS && mem_hit && mem_slot_i.is_load) begin
      sel_o = FWD_LD;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

  always_comb begin
    op_o = rdata_i;
    case (sel_o)
      FWD_RF:  op_o = rdata_i;
      FWD_WB:  op_o = wb_slot_i.data;
      FWD_MEM: op_o = mem_slot_i.data;
      FWD_LD:  op_o = load_data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fwd_bypass_unit.sv
// +----------------------------------------------------------------------------+
// | fwd_bypass_unit: MEM/WB writer tracking, operand forwarding, load-use stall|
// | Build option: FWD_LOAD_BYPASS_EN removes the stall for single-cycle DMEM.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fwd_bypass_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = FWD_XLEN,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned REG_AW = FWD_REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adv_i,
  input  logic                   flush_i,
  input  logic                   ex_valid_i,
  input  logic [REG_AW-1:0]      ex_rd_i,
  input  logic                   ex_we_i,
  input  logic                   ex_is_load_i,
  input  logic [XLEN-1:0]        ex_result_i,
  input  logic [NSRC*REG_AW-1:0] ex_rs_i,
  input  logic [NSRC*XLEN-1:0]   ex_rdata_i,
  input  logic [XLEN-1:0]        mem_load_data_i,
  output logic [NSRC*XLEN-1:0]   op_o,
  output logic [NSRC*2-1:0]      fwd_sel_o,
  output logic                   stall_o
);

  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

`ifdef FWD_LOAD_BYPASS_EN
  assign stall_o = 1'b0;
`else
  fsm_state_e       state_q;
  logic [NSRC-1:0]  ld_hit;

  for (genvar k = 0; k < NSRC; k++) begin : g_ld_hit
    assign ld_hit[k] = mem_q.is_load && slot_writes(mem_q, ex_rs_i[k*REG_AW +: REG_AW]);
  end

  // Only RUN may stall, so a stall is never followed by another; flush wins.
  assign stall_o = (state_q == RUN) && (|ld_hit) && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     state_q <= stall_o ? STALL : RUN;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end
`endif

  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    if (adv_i || stall_o) begin
      wb_d = mem_q;
      if (mem_q.is_load) begin
        wb_d.data = mem_load_data_i;
      end
      if (stall_o || flush_i || !ex_valid_i) begin
        mem_d = SLOT_BUBBLE;
      end else begin
        mem_d = '{valid: 1'b1, rd: ex_rd_i, we: ex_we_i,
                  is_load: ex_is_load_i, data: ex_result_i};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= SLOT_BUBBLE;
      wb_q  <= SLOT_BUBBLE;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_operand_sel #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
    ) u_sel (
      .mem_slot_i  (mem_q),
      .wb_slot_i   (wb_q),
      .rs_i        (ex_rs_i[k*REG_AW +: REG_AW]),
      .rdata_i     (ex_rdata_i[k*XLEN +: XLEN]),
      .load_data_i (mem_load_data_i),
      .op_o        (op_o[k*XLEN +: XLEN]),
      .sel_o       (fwd_sel_o[k*2 +: 2])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_fwd_bypass_unit.sv
// +----------------------------------------------------------------------------+
// | tb_fwd_bypass_unit: directed + random checks against a pipeline model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fwd_bypass_unit;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            adv, flush, ex_valid, ex_we, ex_ld;
  logic [AW-1:0]   ex_rd;
  logic [31:0]     ex_result, ld_data;
  logic [AW-1:0]   rs_v    [NSRC];
  logic [31:0]     rdata_v [NSRC];
  logic [NSRC*AW-1:0]   ex_rs;
  logic [NSRC*XLEN-1:0] ex_rdata;
  logic [NSRC*XLEN-1:0] op;
  logic [NSRC*2-1:0]    sel;
  logic                 stall;

  always_comb begin
    ex_rs    = '0;
    ex_rdata = '0;
    for (int k = 0; k < NSRC; k++) begin
      ex_rs[k*AW +: AW]      = rs_v[k];
      ex_rdata[k*XLEN +: XLEN] = rdata_v[k];
    end
  end

  fwd_bypass_unit #(.XLEN(XLEN), .NSRC(NSRC), .REG_AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .adv_i           (adv),
    .flush_i         (flush),
    .ex_valid_i      (ex_valid),
    .ex_rd_i         (ex_rd),
    .ex_we_i         (ex_we),
    .ex_is_load_i    (ex_ld),
    .ex_result_i     (ex_result),
    .ex_rs_i         (ex_rs),
    .ex_rdata_i      (ex_rdata),
    .mem_load_data_i (ld_data),
    .op_o            (op),
    .fwd_sel_o       (sel),
    .stall_o         (stall)
  );

  // Model: the two in-flight instructions ahead of EX, youngest first.
  typedef struct {
    bit          v;
    bit          we;
    bit          ld;
    logic [4:0]  rd;
    logic [31:0] data;
  } mslot_t;

  mslot_t m_mem, m_wb;
  bit     m_prev_stall;
  logic   e_stall;
  int     passed = 0;
  int     total  = 0;

  function automatic bit writes(mslot_t s, logic [4:0] r);
    return s.v && s.we && (s.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic exp_stall();
`ifdef FWD_LOAD_BYPASS_EN
    return 1'b0;
`else
    if (rst || m_prev_stall || flush) return 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (m_mem.ld && writes(m_mem, rs_v[k])) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic expect_src(input int k, output logic [1:0] s, output logic [31:0] d);
    s = 2'b00;
    d = rdata_v[k];
    if (writes(m_mem, rs_v[k]) && !m_mem.ld) begin
      s = 2'b10; d = m_mem.data;
`ifdef FWD_LOAD_BYPASS_EN
    end else if (writes(m_mem, rs_v[k]) && m_mem.ld) begin
      s = 2'b11; d = ld_data;
`endif
    end else if (writes(m_wb, rs_v[k])) begin
      s = 2'b01; d = m_wb.data;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    m_mem = '{default: 0};
    m_wb  = '{default: 0};
    m_prev_stall = 1'b0;
  endtask

  task automatic settle_check();
    logic [1:0]  es;
    logic [31:0] ed;
    #1;
    e_stall = exp_stall();
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    for (int k = 0; k < NSRC; k++) begin
      expect_src(k, es, ed);
      chk($sformatf("sel%0d", k), {30'd0, sel[k*2 +: 2]}, {30'd0, es});
      chk($sformatf("op%0d", k), op[k*XLEN +: XLEN], ed);
    end
  endtask

  task automatic advance();
    mslot_t nm, nw;
    nm = m_mem;
    nw = m_wb;
    if (adv || e_stall) begin
      nw = m_mem;
      if (m_mem.ld) nw.data = ld_data;
      if (e_stall || flush || !ex_valid) nm = '{default: 0};
      else nm = '{v: 1'b1, we: ex_we, ld: ex_ld, rd: ex_rd, data: ex_result};
    end
    @(posedge clk);
    m_mem = nm;
    m_wb  = nw;
    m_prev_stall = e_stall;
    if (rst) clear_model();
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                        input logic [31:0] res);
    ex_valid = v; ex_rd = rd; ex_we = we; ex_ld = ld; ex_result = res;
  endtask

  task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1);
    rs_v[0] = r0; rs_v[1] = r1;
    rdata_v[0] = $urandom; rdata_v[1] = $urandom;
  endtask

  initial begin
    rst = 1'b1; adv = 1'b0; flush = 1'b0; ld_data = '0;
    set_ex(0, 0, 0, 0, 0);
    set_rs(5'd3, 5'd4);
    clear_model();

    // reset state
    settle_check();
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    advance();
    rst = 1'b0;

    // back-to-back ALU dependency
    adv = 1'b1;
    set_ex(1, 5'd5, 1, 0, 32'h10); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    set_ex(1, 5'd6, 1, 0, 32'hAB); set_rs(5'd5, 5'd21);
    settle_check();
    chk("b2b_sel0", {30'd0, sel[1:0]}, 32'h2);
    chk("b2b_op0", op[31:0], 32'h10);
    advance();

    // distance-2 dependency with intervening x7 writer
    set_ex(1, 5'd7, 1, 0, 32'h77); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    set_ex(1, 5'd0, 0, 0, 32'h0); set_rs(5'd20, 5'd6);
    settle_check();
    chk("dist2_sel1", {30'd0, sel[3:2]}, 32'h1);
    chk("dist2_op1", op[63:32], 32'hAB);
    advance();

    // double writer, MEM is youngest
    set_ex(1, 5'd5, 1, 0, 32'h1); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    set_ex(1, 5'd5, 1, 0, 32'h2); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    set_ex(1, 5'd0, 0, 0, 32'h0); set_rs(5'd5, 5'd0);
    settle_check();
    chk("dbl_sel0", {30'd0, sel[1:0]}, 32'h2);
    chk("dbl_op0", op[31:0], 32'h2);
    chk("x0_sel1", {30'd0, sel[3:2]}, 32'h0);
    advance();

    // MEM writes x0, EX reads x0
    set_ex(1, 5'd0, 1, 0, 32'h55); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    set_ex(1, 5'd0, 0, 0, 32'h0); set_rs(5'd0, 5'd21);
    rdata_v[0] = 32'h0;
    settle_check();
    chk("x0mem_sel0", {30'd0, sel[1:0]}, 32'h0);
    chk("x0mem_op0", op[31:0], 32'h0);
    advance();

    // load-use
    set_ex(1, 5'd8, 1, 1, 32'h100); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    ld_data = 32'hDEAD;
    set_ex(1, 5'd0, 0, 0, 32'h0); set_rs(5'd8, 5'd21);
`ifdef FWD_LOAD_BYPASS_EN
    adv = 1'b1;
    settle_check();
    chk("ldbyp_stall", {31'd0, stall}, 32'h0);
    chk("ldbyp_sel0", {30'd0, sel[1:0]}, 32'h3);
    chk("ldbyp_op0", op[31:0], 32'hDEAD);
`else
    adv = 1'b0;
    settle_check();
    chk("lduse_stall", {31'd0, stall}, 32'h1);
`endif
    advance();
    adv = 1'b1;
    settle_check();
    chk("lduse2_stall", {31'd0, stall}, 32'h0);
    chk("lduse2_sel0", {30'd0, sel[1:0]}, 32'h1);
    chk("lduse2_op0", op[31:0], 32'hDEAD);
    advance();

    // flush at advance leaves a bubble
    set_ex(1, 5'd9, 1, 0, 32'h99); set_rs(5'd20, 5'd21); flush = 1'b1;
    settle_check(); advance();
    flush = 1'b0;
    set_ex(1, 5'd0, 0, 0, 32'h0); set_rs(5'd9, 5'd21);
    settle_check();
    chk("flush_sel0", {30'd0, sel[1:0]}, 32'h0);
    chk("flush_op0", op[31:0], rdata_v[0]);
    advance();

    // reset while in STALL
    set_ex(1, 5'd10, 1, 1, 32'h200); set_rs(5'd20, 5'd21);
    settle_check(); advance();
    adv = 1'b0; ld_data = 32'hBEEF;
    set_ex(1, 5'd0, 0, 0, 32'h0); set_rs(5'd10, 5'd10);
    settle_check(); advance();
    settle_check();
    rst = 1'b1;
    clear_model();
    settle_check();
    chk("rststall_stall", {31'd0, stall}, 32'h0);
    chk("rststall_sel", {28'd0, sel}, 32'h0);
    chk("rststall_op1", op[63:32], rdata_v[1]);
    advance();
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      adv   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      set_ex(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), $urandom);
      set_rs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      ld_data = $urandom;
      settle_check();
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fwd_bypass_unit.md
Name: fwd_bypass_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the 5-stage RISC-V core.
- Replaces the per-operand forwarding muxes and the separate forwarding-control logic.
- Tracks in-flight writers in internal MEM and WB slot registers and compares them against NSRC source registers of the EX-stage instruction.
- Drives the forwarded operand values and a one-cycle load-use stall.

Parameters:
- XLEN, 32, data width.
- NSRC, 2, number of source operands compared and forwarded (1..4).
- REG_AW, 5, register index width; index 0 is hard-wired zero.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- adv_i  in  1  pipeline advance; EX instruction moves to MEM this cycle
- flush_i  in  1  kill the EX instruction; it enters MEM as a bubble
- ex_valid_i  in  1  EX slot holds a real instruction
- ex_rd_i  in  REG_AW  EX destination register
- ex_we_i  in  1  EX writes the register file
- ex_is_load_i  in  1  EX is a load
- ex_result_i  in  XLEN  EX ALU result
- ex_rs_i  in  NSRC*REG_AW  EX source indices; src k at [k*REG_AW +: REG_AW]
- ex_rdata_i  in  NSRC*XLEN  register-file read values, same packing
- mem_load_data_i  in  XLEN  load data returned for the MEM-slot instruction
- op_o  out  NSRC*XLEN  forwarded operands
- fwd_sel_o  out  NSRC*2  per-source select: 00 regfile, 01 WB, 10 MEM, 11 MEM load bypass
- stall_o  out  1  load-use stall; holds IF/ID/EX

Behaviour:
- Reset is asynchronous on rst high, and any operation in progress is abandoned.
  - MEM and WB slots: valid=0, rd=0, we=0, is_load=0, data=0.
  - FSM returns to RUN.
  - stall_o=0. op_o equals ex_rdata_i and fwd_sel_o=0 (combinational, all slots invalid).
- A slot "writes r" when valid && we && rd==r && r!=0.
- Slot update is registered and happens when adv_i || stall_o.
  - WB <= MEM. WB.data = MEM.is_load ? mem_load_data_i : MEM.data.
  - When stall_o=1: MEM <= bubble.
  - When flush_i=1 or ex_valid_i=0: MEM <= bubble.
  - Otherwise: MEM <= EX fields, with data = ex_result_i.
- With neither adv_i nor stall_o, both slots hold.
- Per-source selection is combinational, zero latency. Priority, first match wins:
  - MEM writes rs and MEM is not a load: sel 10, op = MEM.data.
  - WB writes rs: sel 01, op = WB.data.
  - Otherwise: sel 00, op = ex_rdata_i.
- A MEM slot that is a load never selects 10.
- rs==0 always gives sel 00 and op = ex_rdata_i.
- Case statements are fully specified; there is no unassigned select code.
- Load-use FSM, states RUN and STALL:
  - RUN -> STALL when the MEM slot is a load that writes any ex_rs. stall_o=1 in the same cycle (Mealy).
  - STALL -> RUN unconditionally after one cycle. stall_o=0 in STALL.
  - During the stall the load moves to WB with its load data, so the next cycle forwards via sel 01.
- A STALL cycle never raises a second consecutive stall.
- Simultaneous stall condition and flush_i: flush_i wins. stall_o=0, MEM <= bubble, FSM stays RUN.
- MEM and WB both write rs: MEM wins (youngest writer).

Optional Feature:
- Macro FWD_LOAD_BYPASS_EN.
- Defined: no load-use stall; stall_o is tied to 0 and the FSM stays in RUN.
  - A MEM-slot load that writes rs selects 11 and op = mem_load_data_i.
  - For single-cycle data memory.
- Undefined: the stall behaviour above applies, and code 11 is never produced.

Decomposition:
- Package fwd_pkg:
  - select encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_LD=2'b11.
  - FSM state enum {RUN, STALL}.
  - slot struct {valid, rd, we, is_load, data}.
- Sub-module fwd_operand_sel: one source's compare-and-mux (slots, rs, rdata -> op, sel), instantiated NSRC times in a generate loop.

Test Plan:
- Back-to-back ALU dependency: add x5=0x10 in EX, adv_i=1. Next instruction rs1=x5 -> fwd_sel[1:0]=10, op0=0x10.
- Distance-2 dependency: x6=0xAB written two instructions earlier, intervening instruction writes x7. rs2=x6 -> sel 01, op1=0xAB.
- Double writer: MEM writes x5=2, WB writes x5=1 -> sel 10, op=2. Also rs=x0 with MEM rd=x0 -> sel 00.
- Load-use: load x8, mem_load_data_i=0xDEAD, next instruction reads x8.
  - stall_o=1 for exactly one cycle.
  - Next cycle sel 01, op=0xDEAD, stall_o=0.
  - With FWD_LOAD_BYPASS_EN: stall_o=0, sel 11, op=0xDEAD in the first cycle.
- Flush/reset:
  - Dependency plus flush_i=1 at adv -> next cycle the MEM slot is a bubble, sel 00.
  - rst asserted mid-STALL -> stall_o=0 immediately, all sel 00.
